// File: rtl/level_peak_hold_pkg.sv
// Shared meter definitions for the level/peak metering chain.
// Holds the default sample width and the hold counter width.
package level_peak_hold_pkg;

  localparam int METER_WIDTH = 16;
  localparam int HOLD_CNT_W  = 8;

  typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

endpackage

// File: rtl/level_peak_hold_level_decay.sv
// Combinational level ballistics: instant attack, exponential release.
// Release step is level >> decay_shift, never smaller than 1.
module level_peak_hold_level_decay #(
  parameter int width   = 16,
  parameter int shift_w = $clog2(width)
) (
  input  logic [width-1:0]   level,
  input  logic [width-1:0]   v,
  input  logic [shift_w-1:0] decay_shift,
  output logic [width-1:0]   level_n
);

  logic [width-1:0] dec_s;
  logic [width-1:0] sub_s;

  // Release step and next level; the subtraction cannot underflow when v < level.
  always_comb begin
    dec_s   = level >> decay_shift;
    sub_s   = '0;
    level_n = level;
    if (dec_s == '0) begin
      dec_s = {{(width-1){1'b0}}, 1'b1};
    end else begin
      dec_s = dec_s;
    end
    sub_s = level - dec_s;
    if (v >= level) begin
      level_n = v;
    end else if (v > sub_s) begin
      level_n = v;
    end else begin
      level_n = sub_s;
    end
  end

endmodule

// File: rtl/level_peak_hold.sv
// Level and peak-hold meter with a one-deep valid/ready output register.
// Peak holds for hold_count below-peak inputs, then falls back to the level.
module level_peak_hold
  import level_peak_hold_pkg::*;
#(
  parameter int width       = METER_WIDTH,
  parameter int hold_count  = 8,
  parameter int decay_shift = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_value,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_level,
  output logic [width-1:0] o_peak
);

  localparam int SHIFT_W = $clog2(width);

  logic [width-1:0] level_r;
  logic [width-1:0] peak_r;
  hold_cnt_t        hold_cnt_r;

  logic [width-1:0] level_n_s;
  logic [width-1:0] peak_n_s;
  hold_cnt_t        hold_n_s;
  logic             accept_s;

  level_peak_hold_level_decay #(
    .width  (width),
    .shift_w(SHIFT_W)
  ) u_level_decay (
    .level      (level_r),
    .v          (i_value),
    .decay_shift(SHIFT_W'(decay_shift)),
    .level_n    (level_n_s)
  );

  assign i_ready  = (!o_valid || o_ready) && !i_clear;
  assign accept_s = i_valid && i_ready;

  // Peak/hold next state; an expired hold lets peak drop onto the new level.
  always_comb begin
    peak_n_s = peak_r;
    hold_n_s = hold_cnt_r;
    if (i_value >= peak_r) begin
      peak_n_s = i_value;
      hold_n_s = hold_cnt_t'(hold_count);
    end else if (hold_cnt_r != '0) begin
      peak_n_s = peak_r;
      hold_n_s = hold_cnt_r - hold_cnt_t'(1);
    end else begin
      peak_n_s = level_n_s;
      hold_n_s = hold_cnt_r;
    end
  end

  // Meter state and output register; clear beats accept and drops any pending output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r    <= '0;
      peak_r     <= '0;
      hold_cnt_r <= '0;
      o_level    <= '0;
      o_peak     <= '0;
      o_valid    <= 1'b0;
    end else if (i_clear) begin
      level_r    <= '0;
      peak_r     <= '0;
      hold_cnt_r <= '0;
      o_level    <= '0;
      o_peak     <= '0;
      o_valid    <= 1'b0;
    end else if (accept_s) begin
      level_r    <= level_n_s;
      peak_r     <= peak_n_s;
      hold_cnt_r <= hold_n_s;
      o_level    <= level_n_s;
      o_peak     <= peak_n_s;
      o_valid    <= 1'b1;
    end else if (o_valid && o_ready) begin
      o_valid    <= 1'b0;
    end else begin
      o_valid    <= o_valid;
    end
  end

endmodule

// File: tb/tb_level_peak_hold.sv
// Directed bench for level_peak_hold; expected readings are queued at drive
// time and compared against each output handshake.
module tb_level_peak_hold;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_clear = 1'b0;
  logic         o_ready = 1'b1;
  logic [W-1:0] i_value = '0;
  logic         i_ready;
  logic         o_valid;
  logic [W-1:0] o_level;
  logic [W-1:0] o_peak;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] exp_e;

  always #5 clk = ~clk;

  level_peak_hold #(.width(W), .hold_count(2), .decay_shift(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_value(i_value),
    .i_clear(i_clear),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_level(o_level),
    .o_peak (o_peak)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input logic [W-1:0] el, input logic [W-1:0] ep);
    i_valid = 1'b1;
    i_value = v;
    sb_q.push_back({el, ep});
    #1;
    chk("send_i_ready", {15'd0, i_ready}, 16'd1);
    tick();
    i_valid = 1'b0;
  endtask

  // Scoreboard: every output handshake consumes one expected reading.
  always @(negedge clk) begin
    if (reset === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_output", 16'(sb_q.size()), 16'd1);
      end else begin
        exp_e = sb_q.pop_front();
        chk("sb_level", o_level, exp_e[2*W-1:W]);
        chk("sb_peak", o_peak, exp_e[W-1:0]);
      end
    end
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_o_valid", {15'd0, o_valid}, 16'd0);
    chk("rst_o_level", o_level, 16'h0000);
    chk("rst_o_peak", o_peak, 16'h0000);
    chk("rst_i_ready", {15'd0, i_ready}, 16'd1);
    tick();

    // Attack
    send(16'h4444, 16'h4444, 16'h4444);
    chk("attack_o_valid", {15'd0, o_valid}, 16'd1);
    chk("attack_o_level", o_level, 16'h4444);

    // Release and hold
    send(16'h0000, 16'h3333, 16'h4444);
    send(16'h0000, 16'h2667, 16'h4444);
    send(16'h0000, 16'h1CCE, 16'h1CCE);
    tick();

    // Clear, then minimum release step from level=peak=3
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clr_o_valid", {15'd0, o_valid}, 16'd0);
    chk("clr_o_level", o_level, 16'h0000);
    chk("clr_o_peak", o_peak, 16'h0000);
    send(16'h0003, 16'h0003, 16'h0003);
    send(16'h0000, 16'h0002, 16'h0003);
    send(16'h0000, 16'h0001, 16'h0003);
    send(16'h0000, 16'h0000, 16'h0000);
    send(16'h0000, 16'h0000, 16'h0000);
    tick();

    // Backpressure: output held, inputs ignored, then back-to-back release
    o_ready = 1'b0;
    send(16'h0800, 16'h0800, 16'h0800);
    repeat (2) begin
      i_valid = 1'b1;
      i_value = 16'hFFFF;
      #1;
      chk("bp_i_ready", {15'd0, i_ready}, 16'd0);
      tick();
      chk("bp_o_valid", {15'd0, o_valid}, 16'd1);
      chk("bp_o_level", o_level, 16'h0800);
      chk("bp_o_peak", o_peak, 16'h0800);
    end
    o_ready = 1'b1;
    i_value = 16'h0400;
    sb_q.push_back({16'h0600, 16'h0800});
    #1;
    chk("b2b_i_ready", {15'd0, i_ready}, 16'd1);
    tick();
    i_valid = 1'b0;
    chk("b2b_o_valid", {15'd0, o_valid}, 16'd1);
    tick();

    // Clear mid-hold with a pending output and a simultaneous input
    o_ready = 1'b0;
    send(16'h2000, 16'h2000, 16'h2000);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_value = 16'h5555;
    #1;
    chk("clrhold_i_ready", {15'd0, i_ready}, 16'd0);
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
    sb_q.delete();
    chk("clrhold_o_valid", {15'd0, o_valid}, 16'd0);
    chk("clrhold_o_level", o_level, 16'h0000);
    chk("clrhold_o_peak", o_peak, 16'h0000);
    o_ready = 1'b1;
    send(16'h1111, 16'h1111, 16'h1111);
    tick();

    // Asynchronous reset while an output is back-pressured
    o_ready = 1'b0;
    send(16'h7777, 16'h7777, 16'h7777);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_o_valid", {15'd0, o_valid}, 16'd0);
    chk("arst_o_level", o_level, 16'h0000);
    chk("arst_o_peak", o_peak, 16'h0000);
    sb_q.delete();
    tick();
    reset = 1'b1;
    o_ready = 1'b1;
    send(16'h0123, 16'h0123, 16'h0123);
    tick();
    tick();

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_peak_hold.md
# level_peak_hold

Downstream consumer of `section_difference`. Takes one per-section magnitude value per handshake and produces two meter readings: a fast-attack / exponential-release `level`, and a `peak` that holds for a programmable number of sections before falling back to `level`. The results drive the display/scaling stage of the audio level meter.

## Interface
- `width`, 16, bit width of input value and both outputs (unsigned).
- `hold_count`, 8, number of below-peak inputs for which `peak` is held; range 0..255.
- `decay_shift`, 2, release factor: each below-level input reduces `level` by `level >> decay_shift`, with a minimum step of 1; range 1..width-1.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  `i_value` is valid.
- `i_ready`  out  1  block accepts input this cycle.
- `i_value`  in  width  unsigned section magnitude from `section_difference`.
- `i_clear`  in  1  synchronous clear of meter state.
- `o_valid`  out  1  `o_level`/`o_peak` are valid.
- `o_ready`  in  1  downstream accepts output this cycle.
- `o_level`  out  width  decaying level.
- `o_peak`  out  width  held peak.

## Operation
- State registers: `level`, `peak` (width bits each), `hold_cnt` (8 bits), and the output register (`o_level`, `o_peak`, `o_valid`).
- Input accept: `i_valid && i_ready`. Let `v = i_value`.
- Decay step: `dec = level >> decay_shift`. If `dec == 0`, then `dec = 1`.
- Level update:
  - if `v >= level`: `level_n = v`.
  - else: `level_n = max(v, level - dec)`.
  - Subtraction never underflows, because `dec <= level` whenever `level > v >= 0`.
- Peak update (uses `level_n`):
  - if `v >= peak`: `peak_n = v` and `hold_cnt <= hold_count`.
  - else if `hold_cnt != 0`: `peak_n = peak` and `hold_cnt` decrements.
  - else: `peak_n = max(level_n, ...)`, i.e. `peak_n = level_n`.
  - Invariant: `peak >= level` at all times.
- On accept, `level`, `peak`, `o_level`, and `o_peak` all load the `_n` values, and `o_valid` is set to 1.
- Clear (`i_clear == 1`):
  - next edge sets `level`, `peak`, `hold_cnt`, `o_level`, `o_peak` to 0 and `o_valid` to 0.
  - has priority over a simultaneous accept; `i_ready` is forced to 0 while `i_clear` is high.
  - an output pending at clear time is discarded.
- Reset (asserted): all state and outputs are 0. Reset mid-hold or mid-backpressure discards everything immediately, asynchronously.

## Timing
- Reset values: `o_valid = 0`, `o_level = 0`, `o_peak = 0`. `i_ready = 1` once reset deasserts (provided `i_clear` is low).
- Combinational ready: `i_ready = (!o_valid || o_ready) && !i_clear`. One-deep output buffer.
- Latency: input accepted at edge N gives results on `o_*` with `o_valid = 1` after edge N (visible in cycle N+1).
- Output handshake:
  - `o_valid` stays high and `o_level`/`o_peak` stay stable until `o_valid && o_ready`.
  - If a new accept happens in the same cycle as the output handshake, `o_valid` stays 1 and the new values load. Full throughput: 1 value per clock.
  - If the output handshake happens without an accept, `o_valid` goes to 0 on the next edge.
- While `i_ready = 0`, `i_value` is ignored and no state changes.
- `hold_count = 0`: peak tracks `level_n` on every below-peak input.

## Structure
- Shared meter package/header holds:
  - default `width` (16), shared with `section_difference`;
  - the hold counter width constant (8).
- One natural sub-module: `level_decay`, purely combinational. Inputs are `level`, `v`, and `decay_shift`; output is `level_n` (including the minimum-step-1 rule). It is reusable by future meter ballistics.
- The top level holds the handshake, the peak/hold logic, and the registers.

## Test plan
All scenarios use `width=16`, `hold_count=2`, `decay_shift=2`, and `o_ready=1` unless stated otherwise.

1. **Reset.** Hold `reset` low for 2 cycles, then release.
   - Required: `o_valid=0`, `o_level=0`, `o_peak=0`, `i_ready=1`.
2. **Attack.** Send one value, 0x4444.
   - Required, next cycle: `o_level=0x4444`, `o_peak=0x4444`, `o_valid=1`.
3. **Release and hold.** After scenario 2, send 0x0000 three times.
   - `o_level` sequence: 0x3333, 0x2667, 0x1CCE.
   - `o_peak` sequence: 0x4444, 0x4444, 0x1CCE.
4. **Minimum step.** With `level=3` and `peak=3`, send 0x0000 four times.
   - Required: `o_level` = 2, 1, 0, 0.
   - `o_peak` is held for 2 inputs (3, 3), then tracks `level` (0, 0).
5. **Backpressure.** Hold `o_ready=0` after one accept.
   - Required: `i_ready=0`, `o_*` stable, later `i_value` pulses ignored.
   - Raise `o_ready` together with `i_valid`: back-to-back transfer, `o_valid` stays 1.
6. **Clear mid-hold.** Pulse `i_clear` during scenario 3 while a result is pending, with `i_valid=1` in the same cycle.
   - Required: input not accepted, next cycle `o_valid=0` and `o_level`, `o_peak` = 0.
   - Next input 0x1111 gives `o_level` = `o_peak` = 0x1111.
